amiq_muxn_1: RTL and testbench

Parametrised, registered N-to-1 multiplexer, the successor to the two-input registered mux used as the DUT in the socket-driven stimulus benches. Generalised in channel count and data width, it adds per-channel valid qualification, a round-robin auto-select mode, illegal-select detection and a saturating transfer counter. It sits between stimulus drivers and a checker in the SV/Python co-simulation environment.

---
 rtl/amiq_muxn_1.sv | 192 +++++++++++++++++++
 tb/tb_amiq_muxn_1.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amiq_muxn_1.sv
// amiq_muxn_1 - registered N-to-1 multiplexer with per-channel valid,
// direct or round-robin channel selection, illegal-select detection and a
// saturating count of valid output cycles.
//
// Optional feature: define AMIQ_MUXN_PARITY_EN to add the out_parity port,
// an even-parity bit registered alongside out_data. With the macro
// undefined the port and its logic are absent and nothing else changes.
//
// All outputs come straight from flops; nothing on an input reaches an
// output without passing through a register first.

module amiq_muxn_1 #(
  parameter int NOF_IN = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(NOF_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_load,
  input  logic [NOF_IN*WIDTH-1:0] in_data,
  input  logic [NOF_IN-1:0]       in_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    sel_err,
`ifdef AMIQ_MUXN_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [15:0]             out_cnt
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NOF_IN - 1);
  localparam logic [15:0]      CNT_MAX = 16'hFFFF;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Channel slices of the flat input bus, unpacked for clean indexing.
  logic [WIDTH-1:0] ch_data [NOF_IN];

  for (genvar g = 0; g < NOF_IN; g++) begin : g_slice
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Internal selection state.
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] last_grant;

  // Next-state values computed by the selection logic.
  logic [SEL_W-1:0] pick;
  logic             take;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_valid;
  logic [SEL_W-1:0] nxt_ch;
  logic [SEL_W-1:0] nxt_cur_sel;
  logic [SEL_W-1:0] nxt_last_grant;
  logic             nxt_sel_err;

  // Round-robin search result.
  logic             rr_hit;
  logic [SEL_W-1:0] rr_pick;

  mode_e mode_q;
  assign mode_q = mode_e'(mode);

  // A select value is legal only when it names an existing channel; for a
  // power-of-two channel count every encoding is legal.
  logic sel_legal;
  assign sel_legal = (int'(sel) < NOF_IN);

  // Scan channels starting just after the previous grant, wrapping modulo
  // NOF_IN, and report the first one with its valid set.
  function automatic void rr_search(
    input  logic [SEL_W-1:0]  from_ch,
    input  logic [NOF_IN-1:0] valid,
    output logic              hit,
    output logic [SEL_W-1:0]  ch
  );
    int idx;
    hit = 1'b0;
    ch  = from_ch;
    for (int i = 1; i <= NOF_IN; i++) begin
      idx = (int'(from_ch) + i) % NOF_IN;
      if (!hit && valid[idx]) begin
        hit = 1'b1;
        ch  = SEL_W'(idx);
      end
    end
  endfunction

  // Round-robin candidate, evaluated every cycle regardless of mode.
  always_comb begin
    rr_search(last_grant, in_valid, rr_hit, rr_pick);
  end

  // Choose the channel to register this cycle and the next selection state.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    pick           = cur_sel;
    take           = 1'b1;
    nxt_cur_sel    = cur_sel;
    nxt_last_grant = last_grant;
    nxt_sel_err    = 1'b0;

    unique case (mode_q)
      MODE_DIRECT: begin
        if (sel_load) begin
          if (sel_legal) begin
            // A legal load steers this very cycle's output.
            pick        = sel;
            nxt_cur_sel = sel;
          end else begin
            // Keep the old channel and flag the bad request.
            nxt_sel_err = 1'b1;
          end
        end
      end
      MODE_RR: begin
        if (rr_hit) begin
          pick           = rr_pick;
          nxt_last_grant = rr_pick;
        end else begin
          // Nothing valid: data and channel hold, only valid drops.
          take = 1'b0;
        end
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

  // Output next values: direct mode passes data even when invalid; a
  // round-robin miss holds data and channel.
  always_comb begin
    nxt_data  = out_data;
    nxt_ch    = out_ch;
    nxt_valid = 1'b0;
    if (take) begin
      nxt_data  = ch_data[pick];
      nxt_ch    = pick;
      nxt_valid = in_valid[pick];
    end
  end

  // Selection state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sel    <= '0;
      last_grant <= LAST_CH;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      sel_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      cur_sel    <= nxt_cur_sel;
      last_grant <= nxt_last_grant;
      out_data   <= nxt_data;
      out_valid  <= nxt_valid;
      out_ch     <= nxt_ch;
      sel_err    <= nxt_sel_err;
    end
  end

  // Count cycles in which out_valid is high, sticking at the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_valid && (out_cnt != CNT_MAX)) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end

`ifdef AMIQ_MUXN_PARITY_EN
  // Even parity of the value being loaded into out_data; holds with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else begin
      out_parity <= ^nxt_data;
    end
  end
`endif

endmodule

// File: tb/tb_amiq_muxn_1.sv
// tb_amiq_muxn_1 - directed-vector bench for amiq_muxn_1. A four-channel
// instance covers direct select, round-robin, reset and counter saturation;
// a three-channel instance covers the illegal-select pulse. Parity vectors
// are included when AMIQ_MUXN_PARITY_EN is defined.

`timescale 1ns/1ps

module tb_amiq_muxn_1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Four-channel instance.
  logic        mode4     = 1'b0;
  logic [1:0]  sel4      = '0;
  logic        sel_load4 = 1'b0;
  logic [31:0] in_data4  = '0;
  logic [3:0]  in_valid4 = '0;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic [1:0]  out_ch4;
  logic        sel_err4;
  logic [15:0] out_cnt4;
`ifdef AMIQ_MUXN_PARITY_EN
  logic        out_parity4;
`endif

  amiq_muxn_1 #(.NOF_IN(4), .WIDTH(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode4),
    .sel        (sel4),
    .sel_load   (sel_load4),
    .in_data    (in_data4),
    .in_valid   (in_valid4),
    .out_data   (out_data4),
    .out_valid  (out_valid4),
    .out_ch     (out_ch4),
    .sel_err    (sel_err4),
`ifdef AMIQ_MUXN_PARITY_EN
    .out_parity (out_parity4),
`endif
    .out_cnt    (out_cnt4)
  );

  // Three-channel instance: select value 3 is illegal here.
  logic        mode3     = 1'b0;
  logic [1:0]  sel3      = '0;
  logic        sel_load3 = 1'b0;
  logic [23:0] in_data3  = {8'hCC, 8'hBB, 8'hAA};
  logic [2:0]  in_valid3 = 3'b111;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;
  logic        sel_err3;
  logic [15:0] out_cnt3;
`ifdef AMIQ_MUXN_PARITY_EN
  logic        out_parity3;
`endif

  amiq_muxn_1 #(.NOF_IN(3), .WIDTH(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode3),
    .sel        (sel3),
    .sel_load   (sel_load3),
    .in_data    (in_data3),
    .in_valid   (in_valid3),
    .out_data   (out_data3),
    .out_valid  (out_valid3),
    .out_ch     (out_ch3),
    .sel_err    (sel_err3),
`ifdef AMIQ_MUXN_PARITY_EN
    .out_parity (out_parity3),
`endif
    .out_cnt    (out_cnt3)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected round-robin sequences.
  logic [1:0] rr_ch_exp   [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
  logic [7:0] rr_data_exp [6] = '{8'hAA, 8'hBB, 8'hDD, 8'hAA, 8'hBB, 8'hDD};
  logic [1:0] rst_ch_exp  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    // Power-on reset.
    #3;
    check("por_data",  64'(out_data4),  64'h0);
    check("por_valid", 64'(out_valid4), 64'h0);
    check("por_ch",    64'(out_ch4),    64'h0);
    check("por_err",   64'(sel_err4),   64'h0);
    check("por_cnt",   64'(out_cnt4),   64'h0);
    tick();
    rst = 1'b0;

    // Direct select of channel 2.
    mode4     = 1'b0;
    in_data4  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid4 = 4'b1111;
    sel4      = 2'd2;
    sel_load4 = 1'b1;
    tick();
    check("dir_data",  64'(out_data4),  64'hCC);
    check("dir_ch",    64'(out_ch4),    64'd2);
    check("dir_valid", 64'(out_valid4), 64'h1);
    check("dir_cnt0",  64'(out_cnt4),   64'd0);
    sel_load4 = 1'b0;
    sel4      = 2'd0;
    tick();
    check("dir_hold_ch",   64'(out_ch4),   64'd2);
    check("dir_hold_data", 64'(out_data4), 64'hCC);
    check("dir_cnt1",      64'(out_cnt4),  64'd1);
    // Channel 2 invalid: data still passes, valid drops.
    in_data4  = {8'hDD, 8'h5C, 8'hBB, 8'hAA};
    in_valid4 = 4'b1011;
    tick();
    check("dir_inv_data",  64'(out_data4),  64'h5C);
    check("dir_inv_valid", 64'(out_valid4), 64'h0);
    check("dir_cnt2",      64'(out_cnt4),   64'd2);
    tick();
    check("dir_cnt_hold",  64'(out_cnt4),   64'd2);

    // Round-robin fairness; sel_load must be ignored.
    mode4     = 1'b1;
    in_data4  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    in_valid4 = 4'b1011;
    sel_load4 = 1'b1;
    sel4      = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr_ch%0d", i),   64'(out_ch4),    64'(rr_ch_exp[i]));
      check($sformatf("rr_data%0d", i), 64'(out_data4),  64'(rr_data_exp[i]));
      check($sformatf("rr_vld%0d", i),  64'(out_valid4), 64'h1);
      check($sformatf("rr_err%0d", i),  64'(sel_err4),   64'h0);
    end
    in_valid4 = 4'b0000;
    tick();
    check("rr_none_valid", 64'(out_valid4), 64'h0);
    check("rr_none_ch",    64'(out_ch4),    64'd3);
    check("rr_none_data",  64'(out_data4),  64'hDD);
    // Back to direct: cur_sel survived the mode switch.
    mode4     = 1'b0;
    sel_load4 = 1'b0;
    in_valid4 = 4'b1111;
    tick();
    check("sw_back_ch",   64'(out_ch4),   64'd2);
    check("sw_back_data", 64'(out_data4), 64'hCC);

    // Reset mid-stream with out_cnt at 5.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    mode4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_rr_ch%0d", i), 64'(out_ch4), 64'(rst_ch_exp[i]));
    end
    check("pre_rst_cnt", 64'(out_cnt4), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("async_data",  64'(out_data4),  64'h0);
    check("async_valid", 64'(out_valid4), 64'h0);
    check("async_ch",    64'(out_ch4),    64'h0);
    check("async_err",   64'(sel_err4),   64'h0);
    check("async_cnt",   64'(out_cnt4),   64'h0);
    rst = 1'b0;
    tick();
    check("post_rst_ch",    64'(out_ch4),    64'd0);
    check("post_rst_valid", 64'(out_valid4), 64'h1);
    check("post_rst_data",  64'(out_data4),  64'hAA);

    // Illegal select on the three-channel instance.
    mode3     = 1'b0;
    sel3      = 2'd1;
    sel_load3 = 1'b1;
    tick();
    check("ill_pre_ch",  64'(out_ch3),  64'd1);
    check("ill_pre_err", 64'(sel_err3), 64'h0);
    sel3 = 2'd3;
    tick();
    check("ill_err1",  64'(sel_err3),  64'h1);
    check("ill_ch1",   64'(out_ch3),   64'd1);
    check("ill_data1", 64'(out_data3), 64'hBB);
    tick();
    check("ill_err2",  64'(sel_err3),  64'h1);
    check("ill_ch2",   64'(out_ch3),   64'd1);
    sel_load3 = 1'b0;
    tick();
    check("ill_err_clr", 64'(sel_err3), 64'h0);
    check("ill_ch_keep", 64'(out_ch3),  64'd1);

`ifdef AMIQ_MUXN_PARITY_EN
    // Parity follows the registered data.
    mode4     = 1'b0;
    in_data4  = {8'h00, 8'h00, 8'h03, 8'h07};
    sel4      = 2'd0;
    sel_load4 = 1'b1;
    tick();
    check("par_07", 64'(out_parity4), 64'h1);
    sel4 = 2'd1;
    tick();
    check("par_03", 64'(out_parity4), 64'h0);
    sel_load4 = 1'b0;
`endif

    // Counter saturation: after n valid ticks out_cnt is n-1.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    mode4     = 1'b0;
    sel_load4 = 1'b0;
    in_valid4 = 4'b1111;
    repeat (65535) tick();
    check("cnt_fffe", 64'(out_cnt4), 64'hFFFE);
    tick();
    check("cnt_ffff", 64'(out_cnt4), 64'hFFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("cnt_sat%0d", i), 64'(out_cnt4), 64'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
